control_sequencer: RTL and testbench

- Timing-and-control stage of the SAP-1 datapath, directly downstream of the instruction decoder.
- A six-state one-hot ring counter (T1..T6) runs fetch (T1-T3) and execute (T4-T6).
- Each cycle it combines the current T-state with the decoder's one-hot instruction strobes to drive the bus/register control word, the ALU op select and the halt state.

---
 rtl/sap_pkg.sv | 72 +++++++
 rtl/control_sequencer_if.sv | 30 +++
 rtl/ring_counter.sv | 24 ++
 rtl/control_sequencer.sv | 135 +++++++++++++
 tb/tb_control_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 timing-and-control stage: ALU function codes,
// one-hot T-state values, control-word bit positions and instruction identifiers.
package sap_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_CMP = 3'b101;

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   // Control-word bits are all "asserted = 1"; active-low pins are inverted at the top.
   localparam int CW_CP   = 0;
   localparam int CW_EP   = 1;
   localparam int CW_LM   = 2;
   localparam int CW_CE   = 3;
   localparam int CW_WE   = 4;
   localparam int CW_LI   = 5;
   localparam int CW_EI   = 6;
   localparam int CW_LA   = 7;
   localparam int CW_EA   = 8;
   localparam int CW_LB   = 9;
   localparam int CW_EU   = 10;
   localparam int CW_SU   = 11;
   localparam int CW_FLAG = 12;
   localparam int CW_LO   = 13;
   localparam int CW_W    = 14;

   typedef enum logic [3:0] {
      INS_NONE,
      INS_LDA,
      INS_ADD,
      INS_SUB,
      INS_XOR,
      INS_AND,
      INS_OR,
      INS_CMP,
      INS_LDA_IMM,
      INS_ADD_IMM,
      INS_STA_IMM,
      INS_OUT
   } instr_e;

   function automatic logic [2:0] alu_op_of(input instr_e ins);
      case (ins)
         INS_SUB: return ALU_SUB;
         INS_XOR: return ALU_XOR;
         INS_AND: return ALU_AND;
         INS_OR:  return ALU_OR;
         INS_CMP: return ALU_CMP;
         default: return ALU_ADD;
      endcase
   endfunction

   // T-state after which a short-cycle machine jumps back to T1.
   function automatic logic [5:0] last_state_of(input instr_e ins);
      case (ins)
         INS_LDA, INS_ADD_IMM, INS_STA_IMM:                   return T5;
         INS_LDA_IMM, INS_OUT:                                return T4;
         INS_ADD, INS_SUB, INS_XOR, INS_AND, INS_OR, INS_CMP: return T6;
         default:                                             return 6'b000000;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Decoder strobes in, bus/register control word out, for the SAP-1 sequencer.
interface control_sequencer_if #(
   parameter int ALU_OP_W = 3
);
   logic lda, add, sub, out, low_halt;
   logic xor_ratna, and_ratna, or_ratna, cmp_ratna;
   logic lda_imm, sta_imm, add_imm;

   logic [5:0]          t_state;
   logic                cp, ep, lm_n, ce_n, we, li_n, ei_n;
   logic                la_n, ea, lb_n, eu, su, flag_en, lo_n;
   logic [ALU_OP_W-1:0] alu_op;
   logic                halted;

   modport slave (
      input  lda, add, sub, out, low_halt,
      input  xor_ratna, and_ratna, or_ratna, cmp_ratna,
      input  lda_imm, sta_imm, add_imm,
      output t_state, cp, ep, lm_n, ce_n, we, li_n, ei_n,
      output la_n, ea, lb_n, eu, su, flag_en, lo_n, alu_op, halted
   );

   modport master (
      output lda, add, sub, out, low_halt,
      output xor_ratna, and_ratna, or_ratna, cmp_ratna,
      output lda_imm, sta_imm, add_imm,
      input  t_state, cp, ep, lm_n, ce_n, we, li_n, ei_n,
      input  la_n, ea, lb_n, eu, su, flag_en, lo_n, alu_op, halted
   );
endinterface

// File: rtl/ring_counter.sv
// Six-state one-hot ring T1..T6; hold freezes the ring and beats restart.
module ring_counter
   import sap_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       hold,
   input  logic       restart,
   output logic [5:0] state
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= T1;
      end else if (!hold) begin
         if (restart) begin
            state <= T1;
         end else begin
            state <= {state[4:0], state[5]};
         end
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 timing and control: ring counter plus a combinational decode of the
// T-state and the winning decoder strobe into the control word.
module control_sequencer
   import sap_pkg::*;
#(
   parameter bit SHORT_CYCLE = 1'b0,
   parameter int ALU_OP_W    = 3
) (
   input logic                clk,
   input logic                clr,
   control_sequencer_if.slave bus
);

   logic [5:0]      t_state;
   logic            halted;
   logic            halt_now;
   logic            hold;
   logic            restart;
   instr_e          ins;
   logic [CW_W-1:0] cw;
   logic [2:0]      op;

   // Several strobes may be high at once; the fixed priority picks one winner.
   always_comb begin
      ins = INS_NONE;
      if      (bus.lda)       ins = INS_LDA;
      else if (bus.add)       ins = INS_ADD;
      else if (bus.sub)       ins = INS_SUB;
      else if (bus.xor_ratna) ins = INS_XOR;
      else if (bus.and_ratna) ins = INS_AND;
      else if (bus.or_ratna)  ins = INS_OR;
      else if (bus.cmp_ratna) ins = INS_CMP;
      else if (bus.lda_imm)   ins = INS_LDA_IMM;
      else if (bus.add_imm)   ins = INS_ADD_IMM;
      else if (bus.sta_imm)   ins = INS_STA_IMM;
      else if (bus.out)       ins = INS_OUT;
   end

   assign halt_now = !halted && (t_state == T4) && !bus.low_halt;
   assign hold     = halted || halt_now;
   assign restart  = SHORT_CYCLE &&
                     (((ins != INS_NONE) && (t_state == last_state_of(ins))) ||
                      ((ins == INS_NONE) && (t_state == T4)));

   ring_counter u_ring (
      .clk     (clk),
      .clr     (clr),
      .hold    (hold),
      .restart (restart),
      .state   (t_state)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         halted <= 1'b0;
      end else if (halt_now) begin
         halted <= 1'b1;
      end
   end

   // Fetch is instruction independent; execute steps depend on the winner.
   always_comb begin
      cw = '0;
      op = ALU_ADD;
      if (!halted) begin
         case (t_state)
            T1: begin cw[CW_EP] = 1'b1; cw[CW_LM] = 1'b1; end
            T2: cw[CW_CP] = 1'b1;
            T3: begin cw[CW_CE] = 1'b1; cw[CW_LI] = 1'b1; end
            T4: begin
               case (ins)
                  INS_LDA, INS_ADD, INS_SUB, INS_XOR, INS_AND, INS_OR, INS_CMP, INS_STA_IMM: begin
                     cw[CW_EI] = 1'b1; cw[CW_LM] = 1'b1;
                  end
                  INS_LDA_IMM: begin cw[CW_EI] = 1'b1; cw[CW_LA] = 1'b1; end
                  INS_ADD_IMM: begin cw[CW_EI] = 1'b1; cw[CW_LB] = 1'b1; end
                  INS_OUT:     begin cw[CW_EA] = 1'b1; cw[CW_LO] = 1'b1; end
                  default: ;
               endcase
            end
            T5: begin
               case (ins)
                  INS_LDA: begin cw[CW_CE] = 1'b1; cw[CW_LA] = 1'b1; end
                  INS_ADD, INS_SUB, INS_XOR, INS_AND, INS_OR, INS_CMP: begin
                     cw[CW_CE] = 1'b1; cw[CW_LB] = 1'b1;
                  end
                  INS_ADD_IMM: begin
                     cw[CW_EU] = 1'b1; cw[CW_LA] = 1'b1; cw[CW_FLAG] = 1'b1;
                     op = ALU_ADD;
                  end
                  INS_STA_IMM: begin cw[CW_EA] = 1'b1; cw[CW_WE] = 1'b1; end
                  default: ;
               endcase
            end
            T6: begin
               case (ins)
                  INS_ADD, INS_SUB, INS_XOR, INS_AND, INS_OR: begin
                     cw[CW_EU]   = 1'b1;
                     cw[CW_LA]   = 1'b1;
                     cw[CW_FLAG] = 1'b1;
                     cw[CW_SU]   = (ins == INS_SUB);
                     op          = alu_op_of(ins);
                  end
                  INS_CMP: begin
                     cw[CW_FLAG] = 1'b1;
                     cw[CW_SU]   = 1'b1;
                     op          = ALU_CMP;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign bus.t_state = t_state;
   assign bus.halted  = halted;
   assign bus.alu_op  = ALU_OP_W'(op);
   assign bus.cp      = cw[CW_CP];
   assign bus.ep      = cw[CW_EP];
   assign bus.lm_n    = ~cw[CW_LM];
   assign bus.ce_n    = ~cw[CW_CE];
   assign bus.we      = cw[CW_WE];
   assign bus.li_n    = ~cw[CW_LI];
   assign bus.ei_n    = ~cw[CW_EI];
   assign bus.la_n    = ~cw[CW_LA];
   assign bus.ea      = cw[CW_EA];
   assign bus.lb_n    = ~cw[CW_LB];
   assign bus.eu      = cw[CW_EU];
   assign bus.su      = cw[CW_SU];
   assign bus.flag_en = cw[CW_FLAG];
   assign bus.lo_n    = ~cw[CW_LO];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a long-cycle and a short-cycle instance share
// stimulus and are both compared every cycle against a table-driven model.
module tb_control_sequencer;

   logic clk;
   logic clr;
   int   checks = 0;
   int   passes = 0;

   control_sequencer_if #(.ALU_OP_W(3)) if0 ();
   control_sequencer_if #(.ALU_OP_W(3)) if1 ();

   control_sequencer #(.SHORT_CYCLE(1'b0), .ALU_OP_W(3)) dut0 (.clk(clk), .clr(clr), .bus(if0));
   control_sequencer #(.SHORT_CYCLE(1'b1), .ALU_OP_W(3)) dut1 (.clk(clk), .clr(clr), .bus(if1));

   logic lda, add, sub, out, low_halt, xor_ratna, and_ratna, or_ratna, cmp_ratna;
   logic lda_imm, sta_imm, add_imm;

   assign {if0.lda, if0.add, if0.sub, if0.out, if0.low_halt} = {lda, add, sub, out, low_halt};
   assign {if1.lda, if1.add, if1.sub, if1.out, if1.low_halt} = {lda, add, sub, out, low_halt};
   assign {if0.xor_ratna, if0.and_ratna, if0.or_ratna, if0.cmp_ratna} = {xor_ratna, and_ratna, or_ratna, cmp_ratna};
   assign {if1.xor_ratna, if1.and_ratna, if1.or_ratna, if1.cmp_ratna} = {xor_ratna, and_ratna, or_ratna, cmp_ratna};
   assign {if0.lda_imm, if0.sta_imm, if0.add_imm} = {lda_imm, sta_imm, add_imm};
   assign {if1.lda_imm, if1.sta_imm, if1.add_imm} = {lda_imm, sta_imm, add_imm};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model word layout: {t_state, halted, alu_op, 14 asserted-high control bits}.
   localparam int B_CP = 13, B_EP = 12, B_LM = 11, B_CE = 10, B_WE = 9, B_LI = 8, B_EI = 7;
   localparam int B_LA = 6, B_EA = 5, B_LB = 4, B_EU = 3, B_SU = 2, B_FLAG = 1, B_LO = 0;

   function automatic logic [23:0] word_of(input logic [5:0] t, input logic h, input logic [2:0] op,
                                           input logic cp, ep, lm_n, ce_n, we, li_n, ei_n,
                                           input logic la_n, ea, lb_n, eu, su, fl, lo_n);
      return {t, h, op, cp, ep, ~lm_n, ~ce_n, we, ~li_n, ~ei_n, ~la_n, ea, ~lb_n, eu, su, fl, ~lo_n};
   endfunction

   logic [23:0] act [2];
   assign act[0] = word_of(if0.t_state, if0.halted, if0.alu_op, if0.cp, if0.ep, if0.lm_n, if0.ce_n,
                           if0.we, if0.li_n, if0.ei_n, if0.la_n, if0.ea, if0.lb_n, if0.eu, if0.su,
                           if0.flag_en, if0.lo_n);
   assign act[1] = word_of(if1.t_state, if1.halted, if1.alu_op, if1.cp, if1.ep, if1.lm_n, if1.ce_n,
                           if1.we, if1.li_n, if1.ei_n, if1.la_n, if1.ea, if1.lb_n, if1.eu, if1.su,
                           if1.flag_en, if1.lo_n);

   function automatic logic [13:0] bit_of(input int b);
      return 14'(1) << b;
   endfunction

   // Per-instruction execute table (T4,T5,T6) indexed by priority rank; 11 = no strobe.
   logic [13:0] step_mask [12][3];
   logic [2:0]  step_op   [12][3];
   int          last_t    [12];

   initial begin
      logic [13:0] mar;
      mar = bit_of(B_EI) | bit_of(B_LM);
      for (int i = 0; i < 12; i++) begin
         for (int s = 0; s < 3; s++) begin
            step_mask[i][s] = '0;
            step_op[i][s]   = 3'd0;
         end
         last_t[i] = 0;
      end
      step_mask[0][0] = mar;
      step_mask[0][1] = bit_of(B_CE) | bit_of(B_LA);
      last_t[0] = 5;
      for (int i = 1; i <= 6; i++) begin
         step_mask[i][0] = mar;
         step_mask[i][1] = bit_of(B_CE) | bit_of(B_LB);
         step_mask[i][2] = bit_of(B_EU) | bit_of(B_LA) | bit_of(B_FLAG);
         step_op[i][2]   = 3'(i - 1);
         last_t[i] = 6;
      end
      step_mask[2][2] = step_mask[2][2] | bit_of(B_SU);
      step_mask[6][2] = bit_of(B_FLAG) | bit_of(B_SU);
      step_mask[7][0] = bit_of(B_EI) | bit_of(B_LA);
      last_t[7] = 4;
      step_mask[8][0] = bit_of(B_EI) | bit_of(B_LB);
      step_mask[8][1] = bit_of(B_EU) | bit_of(B_LA) | bit_of(B_FLAG);
      last_t[8] = 5;
      step_mask[9][0] = mar;
      step_mask[9][1] = bit_of(B_EA) | bit_of(B_WE);
      last_t[9] = 5;
      step_mask[10][0] = bit_of(B_EA) | bit_of(B_LO);
      last_t[10] = 4;
   end

   function automatic int winner();
      logic [10:0] prio;
      prio = {out, sta_imm, add_imm, lda_imm, cmp_ratna, or_ratna, and_ratna, xor_ratna, sub, add, lda};
      for (int i = 0; i < 11; i++) if (prio[i]) return i;
      return 11;
   endfunction

   function automatic logic [23:0] model_word(input int t, input bit h, input int w);
      logic [13:0] m;
      logic [2:0]  op;
      m  = '0;
      op = 3'd0;
      if (!h) begin
         case (t)
            1: m = bit_of(B_EP) | bit_of(B_LM);
            2: m = bit_of(B_CP);
            3: m = bit_of(B_CE) | bit_of(B_LI);
            default: begin
               m  = step_mask[w][t-4];
               op = step_op[w][t-4];
            end
         endcase
      end
      return {6'(1 << (t - 1)), h, op, m};
   endfunction

   int m_t [2] = '{1, 1};
   bit m_h [2] = '{1'b0, 1'b0};
   bit m_short [2] = '{1'b0, 1'b1};

   always @(posedge clk or posedge clr) begin
      int w;
      if (clr) begin
         for (int d = 0; d < 2; d++) begin m_t[d] = 1; m_h[d] = 1'b0; end
      end else begin
         w = winner();
         for (int d = 0; d < 2; d++) begin
            if (m_h[d]) begin
            end else if (m_t[d] == 4 && !low_halt) begin
               m_h[d] = 1'b1;
            end else if (m_short[d] && ((w != 11 && m_t[d] == last_t[w]) || (w == 11 && m_t[d] == 4))) begin
               m_t[d] = 1;
            end else begin
               m_t[d] = (m_t[d] % 6) + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [23:0] exp_w;
      for (int d = 0; d < 2; d++) begin
         exp_w = model_word(m_t[d], m_h[d], winner());
         checks++;
         if (act[d] === exp_w) passes++;
         else $display("[TB] FAIL dut%0d word @%0t: got %h, want %h", d, $time, act[d], exp_w);
      end
   end

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("[TB] FAIL %s @%0t: got %h, want %h", name, $time, got, want);
   endtask

   task automatic wait_state(input int d, input logic [5:0] tgt);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = ((d == 0) ? if0.t_state : if1.t_state) == tgt;
      end
      checks++;
      if (ok) passes++;
      else $display("[TB] FAIL wait dut%0d t_state: got none, want %h", d, tgt);
   endtask

   task automatic apply_stimulus(input logic [10:0] prio);
      {out, sta_imm, add_imm, lda_imm, cmp_ratna, or_ratna, and_ratna, xor_ratna, sub, add, lda} = prio;
   endtask

   task automatic pulse_reset();
      @(negedge clk); #1 clr = 1'b1;
      @(negedge clk); #1 clr = 1'b0;
   endtask

   initial begin
      clr = 1'b1;
      low_halt = 1'b1;
      apply_stimulus(11'd0);
      repeat (2) @(negedge clk);
      check_output("reset t_state", 32'(if0.t_state), 32'h01);
      check_output("reset ep", 32'(if0.ep), 32'h1);
      check_output("reset lm_n", 32'(if0.lm_n), 32'h0);
      check_output("reset halted", 32'(if1.halted), 32'h0);

      // lda held, long cycle: full ring twice
      #1 apply_stimulus(11'b000_0000_0001);
      clr = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check_output("lda ring", 32'(if0.t_state), 32'(1 << ((k + 1) % 6)));
         if ((k + 1) % 6 == 4) begin
            check_output("lda T5 ce_n", 32'(if0.ce_n), 32'h0);
            check_output("lda T5 la_n", 32'(if0.la_n), 32'h0);
         end
         if ((k + 1) % 6 == 5) begin
            check_output("lda T6 hi", 32'({if0.cp, if0.ep, if0.we, if0.ea, if0.eu, if0.su, if0.flag_en, if0.alu_op}), 32'h0);
            check_output("lda T6 lo", 32'({if0.lm_n, if0.ce_n, if0.li_n, if0.ei_n, if0.la_n, if0.lb_n, if0.lo_n}), 32'h7F);
         end
      end

      // asynchronous clr in the middle of T5
      wait_state(0, 6'b010000);
      #2 clr = 1'b1;
      #1;
      check_output("async clr t_state", 32'(if0.t_state), 32'h01);
      check_output("async clr ep", 32'(if0.ep), 32'h1);
      check_output("async clr lm_n", 32'(if0.lm_n), 32'h0);
      check_output("async clr halted", 32'(if0.halted), 32'h0);
      @(negedge clk); #1 clr = 1'b0;

      // add and and_ratna together: add wins
      apply_stimulus(11'b000_0001_0010);
      wait_state(0, 6'b100000);
      check_output("add T6 alu_op", 32'(if0.alu_op), 32'h0);
      check_output("add T6 eu/la_n/flag/su", 32'({if0.eu, if0.la_n, if0.flag_en, if0.su}), 32'b1010);

      apply_stimulus(11'b000_0100_0000);
      pulse_reset();
      wait_state(0, 6'b100000);
      check_output("cmp T6 alu_op", 32'(if0.alu_op), 32'h5);
      check_output("cmp T6 su/flag/la_n", 32'({if0.su, if0.flag_en, if0.la_n}), 32'b111);

      // short cycle returns
      apply_stimulus(11'b000_1000_0000);
      pulse_reset();
      wait_state(1, 6'b001000);
      check_output("lda_imm T4 ei_n/la_n", 32'({if1.ei_n, if1.la_n}), 32'h0);
      @(negedge clk);
      check_output("lda_imm return", 32'(if1.t_state), 32'h01);

      apply_stimulus(11'b010_0000_0000);
      pulse_reset();
      wait_state(1, 6'b010000);
      check_output("sta_imm T5 we", 32'(if1.we), 32'h1);
      @(negedge clk);
      check_output("sta_imm return", 32'(if1.t_state), 32'h01);

      // halt at T4
      apply_stimulus(11'b000_0000_0001);
      pulse_reset();
      wait_state(0, 6'b001000);
      #1 low_halt = 1'b0;
      @(negedge clk);
      check_output("halt halted", 32'(if0.halted), 32'h1);
      #1 low_halt = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_output("halt t_state", 32'(if0.t_state), 32'h08);
         check_output("halt ei_n/lm_n", 32'({if0.ei_n, if0.lm_n, if0.ep}), 32'b110);
      end
      #1 clr = 1'b1;
      #1;
      check_output("unhalt t_state", 32'(if0.t_state), 32'h01);
      check_output("unhalt halted", 32'(if0.halted), 32'h0);
      @(negedge clk); #1 clr = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
